multicyc_muldiv: RTL and testbench
==================================

// Module: multicyc_muldiv
//
// PURPOSE
//   Parametrised multi-cycle HI/LO execution unit for the integer pipeline. It covers
//   MULT/MULTU, MADD/MADDU, MSUB/MSUBU, DIV/DIVU and MTHI/MTLO. Multiplies run through a
//   pipelined multiplier of configurable depth; divides run through an iterative radix-2
//   divider. Requests and responses use valid/ready handshakes with response backpressure,
//   and a flush input kills in-flight work on an exception or branch mispredict.
//
// PARAMETERS
//   XLEN        32  operand width; HI/LO are XLEN bits each, the result is 2*XLEN bits
//   MUL_LAT      2  multiplier pipeline depth in cycles, >=1
//   DIV_EARLY    1  1 = skip leading-zero dividend bits in the divider (variable latency)
//
// PORTS
//   clk          in   1        clock
//   rst_n        in   1        synchronous reset, active-low
//   flush        in   1        abort current operation; top priority
//   req_valid    in   1        request present
//   req_ready    out  1        unit can accept a request
//   req_op       in   4        0 MULT,1 MULTU,2 DIV,3 DIVU,4 MADD,5 MADDU,6 MSUB,7 MSUBU,8 MTHI,9 MTLO; others = NOP
//   req_reg0     in   XLEN     rs / dividend / MTxx source
//   req_reg1     in   XLEN     rt / divisor
//   req_hilo     in   2*XLEN   current {HI,LO}
//   resp_valid   out  1        result available
//   resp_ready   in   1        consumer takes the result
//   resp_hilo    out  2*XLEN   new {HI,LO}
//   busy         out  1        state != IDLE
//
// BEHAVIOUR
// - Reset (rst_n=0 at a clk edge): state=IDLE, req_ready=1, resp_valid=0, resp_hilo=0, busy=0.
// - Accept: req_valid & req_ready & ~flush. At accept, op, reg0, reg1 and hilo are
//   latched; the inputs are don't-care afterwards. req_ready = (state==IDLE) & ~flush.
// - FSM:
//     IDLE -> MUL   on MUL-class ops
//     IDLE -> DIV   on DIV/DIVU with divisor != 0
//     IDLE -> DONE  on MTxx, NOP or divide-by-zero
//     MUL  -> DONE  after MUL_LAT cycles
//     DIV  -> FIX   when the iteration counter reaches 0
//     FIX  -> DONE  after 1 cycle (sign correction)
//     DONE -> IDLE  on resp_ready
// - Latency from the accept edge to resp_valid=1:
//     MTxx, NOP, div0   1 cycle
//     MUL-class         MUL_LAT+1 cycles
//     DIV               XLEN+2 cycles when DIV_EARLY=0
//   With DIV_EARLY=1 the iteration count is XLEN-lz(|dividend|). A dividend of 0 takes
//   0 iterations, i.e. 2 cycles total.
// - DONE: resp_valid=1 and resp_hilo is held stable until resp_ready. There is no
//   back-to-back accept in the DONE cycle; the next accept is earliest in the cycle after
//   the handshake.
// - Signed ops (MULT, DIV, MADD, MSUB): compute on absolute values.
//     product sign   = reg0[XLEN-1] ^ reg1[XLEN-1]
//     quotient sign  = same XOR
//     remainder sign = dividend sign
//   Arithmetic wraps modulo 2^(2*XLEN) for MADD/MSUB accumulation (hilo +/- product).
// - Result layout:
//     DIV      {HI,LO} = {remainder, quotient}
//     MTHI     {reg0, hilo[XLEN-1:0]}
//     MTLO     {hilo[2X-1:X], reg0}
//     NOP      latched hilo
// - Divide by zero (defined here, UNDEFINED in MIPS32): quotient = all-ones, remainder = dividend.
// - Signed overflow (-2^(XLEN-1) / -1): quotient = -2^(XLEN-1), remainder = 0.
// - flush asserted at a clk edge: state -> IDLE from any state, including DONE with
//   resp_valid high. The result is discarded, resp_valid=0 next cycle, and the divider
//   and multiplier valid bits are cleared. A request presented with flush is not accepted.
// - Reset mid-operation behaves like flush, and resp_hilo is also cleared to 0.
// - Simultaneous resp_ready and flush in DONE: flush wins; the consumer must ignore the
//   result, because flush also squashes the consumer.
//
// TESTING
// - MULT -3 * 7, XLEN=32, MUL_LAT=2: resp_valid 3 cycles after accept;
//   resp_hilo = 64'hFFFF_FFFF_FFFF_FFEB.
// - DIV -7 / 2, DIV_EARLY=0: resp_valid 34 cycles after accept; HI=-1 (32'hFFFF_FFFF),
//   LO=-3 (32'hFFFF_FFFD). DIVU 7 / 0: 1-cycle response, HI=7, LO=32'hFFFF_FFFF.
// - MADDU with hilo=64'hFFFF_FFFF_FFFF_FFFF, reg0=1, reg1=1: resp_hilo = 0 (wrap).
//   MSUB with hilo=0, reg0=2, reg1=3: resp_hilo = 64'hFFFF_FFFF_FFFF_FFFA.
// - Backpressure: hold resp_ready=0 for 5 cycles after resp_valid. resp_hilo stays
//   stable and req_ready stays 0. Raise resp_ready: the next request is accepted the
//   cycle after.
// - Flush during DIV at iteration 10: resp_valid never rises for that op and busy=0 next
//   cycle. A following MTLO reg0=32'h1234 with hilo=0 gives resp_hilo=64'h0000_0000_0000_1234.
// - DIV_EARLY=1, DIVU 5 / 3: latency 5 cycles (3 iterations + 2); HI=2, LO=1.
//   Reset pulsed during a MUL: all outputs return to their reset values.

Source files
------------

// File: rtl/multicyc_muldiv.sv
// Multi-cycle HI/LO execution unit: pipelined multiplier, radix-2 restoring divider,
// MTHI/MTLO moves, valid/ready handshakes with response backpressure and flush.
module multicyc_muldiv #(
    parameter int XLEN      = 32,
    parameter int MUL_LAT   = 2,
    parameter int DIV_EARLY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [XLEN-1:0]   req_reg0,
    input  logic [XLEN-1:0]   req_reg1,
    input  logic [2*XLEN-1:0] req_hilo,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [2*XLEN-1:0] resp_hilo,
    output logic              busy
);
    localparam int CW = $clog2(XLEN + 1);
    localparam int W2 = 2 * XLEN;

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [W2-1:0]      hilo_q, hilo_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic [XLEN-1:0]    dvsr_q, dvsr_d;
    logic [XLEN-1:0]    rem_q, rem_d;
    logic [XLEN-1:0]    quo_q, quo_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [W2-1:0]      mul_pipe_q [MUL_LAT];
    logic [W2-1:0]      mul_pipe_d [MUL_LAT];
    logic [MUL_LAT-1:0] mul_vld_q, mul_vld_d;
    logic [W2-1:0]      resp_hilo_q, resp_hilo_d;

    logic               accept, is_mul, is_div, is_signed;
    logic [XLEN-1:0]    abs_a, abs_b;
    logic [CW-1:0]      n_iter;
    logic [XLEN:0]      rem_sh;
    logic [W2-1:0]      prod, mul_res;

    assign accept     = req_valid && (state_q == S_IDLE) && !flush;
    assign req_ready  = (state_q == S_IDLE) && !flush;
    assign resp_valid = (state_q == S_DONE);
    assign resp_hilo  = resp_hilo_q;
    assign busy       = (state_q != S_IDLE);

    always_comb begin
        is_mul    = (req_op <= 4'd7) && (req_op != 4'd2) && (req_op != 4'd3);
        is_div    = (req_op == 4'd2) || (req_op == 4'd3);
        is_signed = (req_op <= 4'd7) && !req_op[0];
        abs_a     = (is_signed && req_reg0[XLEN-1]) ? -req_reg0 : req_reg0;
        abs_b     = (is_signed && req_reg1[XLEN-1]) ? -req_reg1 : req_reg1;
        // Early termination: iterate only over the significant bits of |dividend|.
        n_iter = CW'(XLEN);
        if (DIV_EARLY != 0) begin
            n_iter = '0;
            for (int unsigned i = 0; i < XLEN; i++) begin
                if (abs_a[i]) n_iter = CW'(i + 1);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        hilo_d      = hilo_q;
        neg_d       = neg_q;
        rneg_d      = rneg_q;
        dvsr_d      = dvsr_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        resp_hilo_d = resp_hilo_q;
        mul_vld_d[0]  = 1'b0;
        mul_pipe_d[0] = mul_pipe_q[0];
        for (int unsigned i = 1; i < MUL_LAT; i++) begin
            mul_vld_d[i]  = mul_vld_q[i-1];
            mul_pipe_d[i] = mul_pipe_q[i-1];
        end

        rem_sh = {rem_q, quo_q[XLEN-1]};
        prod   = neg_q ? -mul_pipe_q[MUL_LAT-1] : mul_pipe_q[MUL_LAT-1];
        case (op_q)
            4'd4, 4'd5: mul_res = hilo_q + prod;
            4'd6, 4'd7: mul_res = hilo_q - prod;
            default:    mul_res = prod;
        endcase

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d   = req_op;
                    hilo_d = req_hilo;
                    neg_d  = is_signed && (req_reg0[XLEN-1] ^ req_reg1[XLEN-1]);
                    rneg_d = is_signed && req_reg0[XLEN-1];
                    dvsr_d = abs_b;
                    if (is_mul) begin
                        mul_vld_d[0]  = 1'b1;
                        mul_pipe_d[0] = W2'(abs_a) * W2'(abs_b);
                        state_d       = S_MUL;
                    end else if (is_div && (req_reg1 != '0)) begin
                        // Pre-align the dividend so the skipped leading zeros never enter the remainder.
                        rem_d   = '0;
                        quo_d   = abs_a << (CW'(XLEN) - n_iter);
                        cnt_d   = n_iter;
                        state_d = (n_iter == '0) ? S_FIX : S_DIV;
                    end else begin
                        state_d = S_DONE;
                        case (req_op)
                            4'd2, 4'd3: resp_hilo_d = {req_reg0, {XLEN{1'b1}}};
                            4'd8:       resp_hilo_d = {req_reg0, req_hilo[XLEN-1:0]};
                            4'd9:       resp_hilo_d = {req_hilo[W2-1:XLEN], req_reg0};
                            default:    resp_hilo_d = req_hilo;
                        endcase
                    end
                end
            end
            S_MUL: begin
                if (mul_vld_q[MUL_LAT-1]) begin
                    resp_hilo_d = mul_res;
                    state_d     = S_DONE;
                end
            end
            S_DIV: begin
                if (rem_sh >= {1'b0, dvsr_q}) begin
                    rem_d = XLEN'(rem_sh - {1'b0, dvsr_q});
                    quo_d = {quo_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = S_FIX;
            end
            S_FIX: begin
                resp_hilo_d = {(rneg_q ? -rem_q : rem_q), (neg_q ? -quo_q : quo_q)};
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (flush) begin
            state_d   = S_IDLE;
            mul_vld_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            hilo_q      <= '0;
            neg_q       <= 1'b0;
            rneg_q      <= 1'b0;
            dvsr_q      <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            mul_vld_q   <= '0;
            resp_hilo_q <= '0;
            for (int unsigned i = 0; i < MUL_LAT; i++) mul_pipe_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            hilo_q      <= hilo_d;
            neg_q       <= neg_d;
            rneg_q      <= rneg_d;
            dvsr_q      <= dvsr_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            mul_vld_q   <= mul_vld_d;
            resp_hilo_q <= resp_hilo_d;
            for (int unsigned i = 0; i < MUL_LAT; i++) mul_pipe_q[i] <= mul_pipe_d[i];
        end
    end
endmodule

// File: tb/tb_multicyc_muldiv.sv
// Bench for multicyc_muldiv: instance 0 has fixed-latency division, instance 1 early termination.
module tb_multicyc_muldiv;
    logic        clk;
    logic        rst_n;
    logic        flush      [2];
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic [3:0]  req_op     [2];
    logic [31:0] req_reg0   [2];
    logic [31:0] req_reg1   [2];
    logic [63:0] req_hilo   [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [63:0] resp_hilo  [2];
    logic        busy       [2];

    int total = 0;
    int bad   = 0;

    multicyc_muldiv #(.XLEN(32), .MUL_LAT(2), .DIV_EARLY(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush[0]), .req_valid(req_valid[0]),
        .req_ready(req_ready[0]), .req_op(req_op[0]), .req_reg0(req_reg0[0]),
        .req_reg1(req_reg1[0]), .req_hilo(req_hilo[0]), .resp_valid(resp_valid[0]),
        .resp_ready(resp_ready[0]), .resp_hilo(resp_hilo[0]), .busy(busy[0])
    );

    multicyc_muldiv #(.XLEN(32), .MUL_LAT(2), .DIV_EARLY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush[1]), .req_valid(req_valid[1]),
        .req_ready(req_ready[1]), .req_op(req_op[1]), .req_reg0(req_reg0[1]),
        .req_reg1(req_reg1[1]), .req_hilo(req_hilo[1]), .resp_valid(resp_valid[1]),
        .resp_ready(resp_ready[1]), .resp_hilo(resp_hilo[1]), .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [63:0] hilo);
        longint      sp;
        logic [63:0] up;
        int          q, r;
        sp = longint'($signed(a)) * longint'($signed(b));
        up = {32'd0, a} * {32'd0, b};
        case (op)
            4'd0: return sp;
            4'd1: return up;
            4'd4: return hilo + sp;
            4'd5: return hilo + up;
            4'd6: return hilo - sp;
            4'd7: return hilo - up;
            4'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            4'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            4'd8:    return {a, hilo[31:0]};
            4'd9:    return {hilo[63:32], a};
            default: return hilo;
        endcase
    endfunction

    function automatic int ref_latency(input int d, input logic [3:0] op,
                                       input logic [31:0] a, input logic [31:0] b);
        logic [31:0] mag;
        int          n;
        if (op inside {4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7}) return 3;
        if ((op == 4'd2 || op == 4'd3) && b != 32'd0) begin
            if (d == 0) return 34;
            mag = (op == 4'd2 && a[31]) ? -a : a;
            n = 0;
            while (mag != 32'd0) begin
                n++;
                mag = mag >> 1;
            end
            return n + 2;
        end
        return 1;
    endfunction

    // Presents one request to an idle unit and waits (bounded) for resp_valid.
    task automatic run_op(input int d, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] hilo,
                          output int lat, output logic [63:0] res);
        req_valid[d] = 1'b1;
        req_op[d]    = op;
        req_reg0[d]  = a;
        req_reg1[d]  = b;
        req_hilo[d]  = hilo;
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        req_op[d]    = 4'($urandom);
        req_reg0[d]  = $urandom;
        req_reg1[d]  = $urandom;
        req_hilo[d]  = {$urandom, $urandom};
        lat = 1;
        while (resp_valid[d] !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (resp_valid[d] !== 1'b1) lat = -1;
        res = resp_hilo[d];
    endtask

    task automatic take_resp(input int d);
        resp_ready[d] = 1'b1;
        @(posedge clk); #1;
        resp_ready[d] = 1'b0;
    endtask

    task automatic test_reset;
        for (int d = 0; d < 2; d++) begin
            total++; if (req_ready[d] !== 1'b1) begin bad++; $display("FAIL reset_req_ready[%0d]: got %b want 1", d, req_ready[d]); end
            total++; if (resp_valid[d] !== 1'b0) begin bad++; $display("FAIL reset_resp_valid[%0d]: got %b want 0", d, resp_valid[d]); end
            total++; if (resp_hilo[d] !== 64'd0) begin bad++; $display("FAIL reset_resp_hilo[%0d]: got %h want 0", d, resp_hilo[d]); end
            total++; if (busy[d] !== 1'b0) begin bad++; $display("FAIL reset_busy[%0d]: got %b want 0", d, busy[d]); end
        end
    endtask

    task automatic test_mul;
        int lat; logic [63:0] res;
        run_op(0, 4'd0, -32'sd3, 32'd7, 64'h1234_5678_9ABC_DEF0, lat, res);
        total++; if (lat !== 3) begin bad++; $display("FAIL mult_latency: got %0d want 3", lat); end
        total++; if (res !== 64'hFFFF_FFFF_FFFF_FFEB) begin bad++; $display("FAIL mult_neg: got %h want ffffffffffffffeb", res); end
        take_resp(0);
        run_op(1, 4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, lat, res);
        total++; if (res !== 64'hFFFF_FFFE_0000_0001) begin bad++; $display("FAIL multu_max: got %h want fffffffe00000001", res); end
        take_resp(1);
    endtask

    task automatic test_madd_msub;
        int lat; logic [63:0] res;
        run_op(0, 4'd5, 32'd1, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF, lat, res);
        total++; if (res !== 64'd0) begin bad++; $display("FAIL maddu_wrap: got %h want 0", res); end
        take_resp(0);
        run_op(0, 4'd6, 32'd2, 32'd3, 64'd0, lat, res);
        total++; if (res !== 64'hFFFF_FFFF_FFFF_FFFA) begin bad++; $display("FAIL msub: got %h want fffffffffffffffa", res); end
        take_resp(0);
    endtask

    task automatic test_div;
        int lat; logic [63:0] res;
        run_op(0, 4'd2, -32'sd7, 32'd2, 64'd0, lat, res);
        total++; if (lat !== 34) begin bad++; $display("FAIL div_latency_fixed: got %0d want 34", lat); end
        total++; if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin bad++; $display("FAIL div_neg: got %h want fffffffffffffffd", res); end
        take_resp(0);
        run_op(0, 4'd3, 32'd7, 32'd0, 64'd0, lat, res);
        total++; if (lat !== 1) begin bad++; $display("FAIL div0_latency: got %0d want 1", lat); end
        total++; if (res !== 64'h0000_0007_FFFF_FFFF) begin bad++; $display("FAIL div0_result: got %h want 00000007ffffffff", res); end
        take_resp(0);
        run_op(1, 4'd3, 32'd5, 32'd3, 64'd0, lat, res);
        total++; if (lat !== 5) begin bad++; $display("FAIL divu_early_latency: got %0d want 5", lat); end
        total++; if (res !== 64'h0000_0002_0000_0001) begin bad++; $display("FAIL divu_early: got %h want 0000000200000001", res); end
        take_resp(1);
        run_op(1, 4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, lat, res);
        total++; if (res !== 64'h0000_0000_8000_0000) begin bad++; $display("FAIL div_overflow: got %h want 0000000080000000", res); end
        take_resp(1);
        run_op(1, 4'd2, 32'd0, 32'd5, 64'hDEAD_BEEF_0000_0001, lat, res);
        total++; if (lat !== 2) begin bad++; $display("FAIL div_zero_dividend_latency: got %0d want 2", lat); end
        total++; if (res !== 64'd0) begin bad++; $display("FAIL div_zero_dividend: got %h want 0", res); end
        take_resp(1);
    endtask

    task automatic test_backpressure;
        int lat; logic [63:0] res;
        run_op(0, 4'd1, 32'd5, 32'd6, 64'd0, lat, res);
        req_valid[0] = 1'b1; req_op[0] = 4'd8; req_reg0[0] = 32'hAAAA; req_hilo[0] = 64'd0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++; if (resp_valid[0] !== 1'b1 || resp_hilo[0] !== 64'd30) begin bad++; $display("FAIL bp_hold: valid=%b hilo=%h want 1/%h", resp_valid[0], resp_hilo[0], 64'd30); end
            total++; if (req_ready[0] !== 1'b0) begin bad++; $display("FAIL bp_req_ready: got %b want 0", req_ready[0]); end
        end
        resp_ready[0] = 1'b1;
        @(posedge clk); #1;
        resp_ready[0] = 1'b0;
        total++; if (busy[0] !== 1'b0 || resp_valid[0] !== 1'b0) begin bad++; $display("FAIL bp_no_accept_in_done: busy=%b valid=%b want 0/0", busy[0], resp_valid[0]); end
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        total++; if (resp_valid[0] !== 1'b1 || resp_hilo[0] !== 64'h0000_AAAA_0000_0000) begin bad++; $display("FAIL bp_next_accept: valid=%b hilo=%h want 1/0000aaaa00000000", resp_valid[0], resp_hilo[0]); end
        take_resp(0);
    endtask

    task automatic test_flush;
        int lat; int seen; logic [63:0] res;
        req_valid[0] = 1'b1; req_op[0] = 4'd3; req_reg0[0] = 32'hFFFF_0000; req_reg1[0] = 32'd9;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        flush[0] = 1'b1;
        @(posedge clk); #1;
        flush[0] = 1'b0;
        total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL flush_div_busy: got %b want 0", busy[0]); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (resp_valid[0] === 1'b1) seen++;
            @(posedge clk); #1;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL flush_div_no_resp: got %0d valid cycles want 0", seen); end
        run_op(0, 4'd9, 32'h1234, 32'd0, 64'd0, lat, res);
        total++; if (res !== 64'h0000_0000_0000_1234 || lat !== 1) begin bad++; $display("FAIL mtlo_after_flush: got %h lat %0d want 0000000000001234 lat 1", res, lat); end
        take_resp(0);
        // Request presented together with flush must be dropped.
        flush[0] = 1'b1; req_valid[0] = 1'b1; req_op[0] = 4'd8;
        #1;
        total++; if (req_ready[0] !== 1'b0) begin bad++; $display("FAIL flush_req_ready: got %b want 0", req_ready[0]); end
        @(posedge clk); #1;
        flush[0] = 1'b0; req_valid[0] = 1'b0;
        total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL flush_blocks_accept: busy %b want 0", busy[0]); end
        // Flush beats resp_ready in DONE.
        run_op(0, 4'd8, 32'd1, 32'd0, 64'd0, lat, res);
        flush[0] = 1'b1; resp_ready[0] = 1'b1;
        @(posedge clk); #1;
        flush[0] = 1'b0; resp_ready[0] = 1'b0;
        total++; if (resp_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin bad++; $display("FAIL flush_in_done: valid=%b busy=%b want 0/0", resp_valid[0], busy[0]); end
        // Flush one cycle into a multiply, then a new multiply must see full latency.
        req_valid[1] = 1'b1; req_op[1] = 4'd1; req_reg0[1] = 32'd11; req_reg1[1] = 32'd13;
        @(posedge clk); #1;
        req_valid[1] = 1'b0; flush[1] = 1'b1;
        @(posedge clk); #1;
        flush[1] = 1'b0;
        run_op(1, 4'd1, 32'd4, 32'd5, 64'd0, lat, res);
        total++; if (lat !== 3 || res !== 64'd20) begin bad++; $display("FAIL mul_after_flush: lat %0d res %h want 3/%h", lat, res, 64'd20); end
        take_resp(1);
    endtask

    task automatic test_random;
        int lat; logic [63:0] res; logic [63:0] hilo; logic [31:0] a, b; logic [3:0] op;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 40; i++) begin
                op = 4'($urandom_range(0, 15));
                a  = $urandom;
                b  = $urandom;
                case ($urandom_range(0, 3))
                    0: ;
                    1: begin a = 32'($urandom_range(0, 40)); b = 32'($urandom_range(1, 9)); end
                    2: b = 32'd0;
                    default: begin a = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'hFFFF_FFFF; b = -32'sd1; end
                endcase
                if (i < 12) op = (i % 2 == 0) ? 4'd2 : 4'd3;
                hilo = {$urandom, $urandom};
                run_op(d, op, a, b, hilo, lat, res);
                total++; if (lat !== ref_latency(d, op, a, b)) begin bad++; $display("FAIL rand_latency[%0d] op=%0d a=%h b=%h: got %0d want %0d", d, op, a, b, lat, ref_latency(d, op, a, b)); end
                total++; if (res !== ref_result(op, a, b, hilo)) begin bad++; $display("FAIL rand_result[%0d] op=%0d a=%h b=%h: got %h want %h", d, op, a, b, res, ref_result(op, a, b, hilo)); end
                take_resp(d);
            end
        end
    endtask

    task automatic test_reset_mid_mul;
        int lat; int seen; logic [63:0] res;
        run_op(1, 4'd1, 32'd3, 32'd3, 64'd0, lat, res);
        take_resp(1);
        req_valid[1] = 1'b1; req_op[1] = 4'd0; req_reg0[1] = 32'd100; req_reg1[1] = 32'd7;
        @(posedge clk); #1;
        req_valid[1] = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        total++; if (busy[1] !== 1'b0 || resp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1) begin bad++; $display("FAIL reset_mid_mul_ctrl: busy=%b valid=%b ready=%b want 0/0/1", busy[1], resp_valid[1], req_ready[1]); end
        total++; if (resp_hilo[1] !== 64'd0) begin bad++; $display("FAIL reset_mid_mul_hilo: got %h want 0", resp_hilo[1]); end
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (resp_valid[1] === 1'b1) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL reset_mid_mul_no_resp: got %0d want 0", seen); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            flush[d] = 1'b0; req_valid[d] = 1'b0; req_op[d] = 4'd0; req_reg0[d] = '0;
            req_reg1[d] = '0; req_hilo[d] = '0; resp_ready[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_reset;
        test_mul;
        test_madd_msub;
        test_div;
        test_backpressure;
        test_flush;
        test_random;
        test_reset_mid_mul;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
